infer_sequencer: RTL and testbench

Top-level run controller for the Braille inference path. It turns a start request plus an image-select switch value into a single start pulse for the pixel feeder, then counts the streamed pixels. It waits for the CNN classification, latches the class, and reports errors: bad selection, short stream, or watchdog timeout. It sits between the board I/O (button/switches/LEDs) and the feeder → CNN datapath.

---
 rtl/infer_pkg.sv | 19 +
 rtl/infer_watchdog.sv | 30 +++
 rtl/infer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_infer_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/infer_pkg.sv
// Shared definitions for the Braille inference run controller.
// Holds the FSM state encoding and the error codes reported on o_err.
package infer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        STREAM   = 3'd2,
        WAIT_CNN = 3'd3,
        DONE     = 3'd4,
        ERR      = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SEL     = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/infer_watchdog.sv
// Cycle watchdog: counts while enabled and flags expiry on reaching TIMEOUT-1.
// Clear has priority over counting; the count saturates at the limit.
module infer_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int WIDTH   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/infer_sequencer.sv
// Run controller for the Braille inference path: start handshake to the feeder,
// pixel counting, CNN result capture and error reporting.
module infer_sequencer
    import infer_pkg::*;
#(
    parameter int TOTAL_PIXELS = 784,
    parameter int NUM_IMG      = 12,
    parameter int SEL_BW       = 4,
    parameter int CLS_BW       = 4,
    parameter int TIMEOUT      = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [SEL_BW-1:0] i_sel,
    input  logic              i_feed_valid,
    input  logic              i_cnn_done,
    input  logic [CLS_BW-1:0] i_cnn_class,
    output logic              o_feed_start,
    output logic [SEL_BW-1:0] o_feed_sel,
    output logic [CLS_BW-1:0] o_class,
    output logic              o_result_valid,
    output logic              o_busy,
    output logic [1:0]        o_err
);

    localparam int PIX_BW = $clog2(TOTAL_PIXELS + 1);
    localparam int WD_BW  = $clog2(TOTAL_PIXELS + TIMEOUT + 1);

    localparam logic [PIX_BW-1:0] PIX_LAST  = PIX_BW'(TOTAL_PIXELS - 1);
    localparam logic [PIX_BW-1:0] PIX_FULL  = PIX_BW'(TOTAL_PIXELS);
    localparam logic [SEL_BW:0]   NUM_IMG_W = (SEL_BW + 1)'(NUM_IMG);

    state_t            state;
    logic              start_prev;
    logic              valid_prev;
    logic [PIX_BW-1:0] pix_cnt;

    logic start_edge;
    logic can_start;
    logic sel_bad;
    logic pix_inc;
    logic last_pixel;
    logic valid_fall;
    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    assign start_edge = i_start & ~start_prev;
    assign can_start  = (state == IDLE) || (state == DONE) || (state == ERR);
    assign sel_bad    = {1'b0, i_sel} >= NUM_IMG_W;
    assign pix_inc    = (state == STREAM) && i_feed_valid && (pix_cnt != PIX_FULL);
    assign last_pixel = (state == STREAM) && i_feed_valid && (pix_cnt == PIX_LAST);
    assign valid_fall = valid_prev & ~i_feed_valid;

    // Held clear outside the counting states, so every state entry starts from zero.
    assign wd_enable = (state == STREAM) || (state == WAIT_CNN);
    assign wd_clear  = !wd_enable || last_pixel;

    infer_watchdog #(
        .TIMEOUT(TIMEOUT),
        .WIDTH  (WD_BW)
    ) u_watchdog (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_prev <= 1'b0;
            valid_prev <= 1'b0;
        end else begin
            start_prev <= i_start;
            valid_prev <= i_feed_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt <= '0;
        end else if (state == LOAD) begin
            pix_cnt <= '0;
        end else if (pix_inc) begin
            pix_cnt <= pix_cnt + PIX_BW'(1);
        end
    end

    // Outputs are set on the transition so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            o_feed_start   <= 1'b0;
            o_feed_sel     <= '0;
            o_class        <= '0;
            o_result_valid <= 1'b0;
            o_busy         <= 1'b0;
            o_err          <= ERR_NONE;
        end else begin
            o_feed_start   <= 1'b0;
            o_result_valid <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (can_start && start_edge) begin
                        o_feed_sel <= i_sel;
                        if (sel_bad) begin
                            state  <= ERR;
                            o_err  <= ERR_SEL;
                            o_busy <= 1'b0;
                        end else begin
                            state        <= LOAD;
                            o_err        <= ERR_NONE;
                            o_feed_start <= 1'b1;
                            o_busy       <= 1'b1;
                        end
                    end else if (state == DONE) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                LOAD: begin
                    state  <= STREAM;
                    o_busy <= 1'b1;
                end
                STREAM: begin
                    // Completing the image outranks both a short-stream fall and timeout.
                    if (last_pixel) begin
                        state <= WAIT_CNN;
                    end else if (valid_fall) begin
                        state  <= ERR;
                        o_err  <= ERR_SHORT;
                        o_busy <= 1'b0;
                    end else if (wd_expire) begin
                        state  <= ERR;
                        o_err  <= ERR_TIMEOUT;
                        o_busy <= 1'b0;
                    end
                end
                WAIT_CNN: begin
                    if (i_cnn_done) begin
                        state          <= DONE;
                        o_class        <= i_cnn_class;
                        o_result_valid <= 1'b1;
                        o_busy         <= 1'b0;
                    end else if (wd_expire) begin
                        state  <= ERR;
                        o_err  <= ERR_TIMEOUT;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_infer_sequencer.sv
// Directed self-checking bench for infer_sequencer: normal runs, bad selection,
// short stream, CNN timeout, ignored stray events and mid-run reset.
module tb_infer_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_start;
    logic [3:0] i_sel;
    logic       i_feed_valid;
    logic       i_cnn_done;
    logic [3:0] i_cnn_class;
    logic       o_feed_start;
    logic [3:0] o_feed_sel;
    logic [3:0] o_class;
    logic       o_result_valid;
    logic       o_busy;
    logic [1:0] o_err;

    int total      = 0;
    int passes     = 0;
    int fs_count   = 0;
    int rv_count   = 0;
    int busy_count = 0;

    infer_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_sel         (i_sel),
        .i_feed_valid  (i_feed_valid),
        .i_cnn_done    (i_cnn_done),
        .i_cnn_class   (i_cnn_class),
        .o_feed_start  (o_feed_start),
        .o_feed_sel    (o_feed_sel),
        .o_class       (o_class),
        .o_result_valid(o_result_valid),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    // Pulse/level counters sample pre-update values at the active edge.
    always @(posedge clk) begin
        if (o_feed_start)   fs_count++;
        if (o_result_valid) rv_count++;
        if (o_busy)         busy_count++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [3:0] sel);
        int fs0;
        fs0 = fs_count;
        i_sel   = sel;
        i_start = 1'b1;
        @(negedge clk);
        check_output("load_feed_start", 32'(o_feed_start), 1);
        check_output("load_busy", 32'(o_busy), 1);
        check_output("load_feed_sel", 32'(o_feed_sel), 32'(sel));
        check_output("load_err_cleared", 32'(o_err), 0);
        i_start = 1'b0;
        @(negedge clk);
        check_output("stream_feed_start_low", 32'(o_feed_start), 0);
        check_output("feed_start_single", 32'(fs_count), 32'(fs0 + 1));
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            i_feed_valid = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic finish_run(input logic [3:0] cls, input int gap);
        int rv0;
        rv0 = rv_count;
        repeat (gap) @(negedge clk);
        check_output("wait_no_result", 32'(o_result_valid), 0);
        i_cnn_class = cls;
        i_cnn_done  = 1'b1;
        @(negedge clk);
        check_output("done_result_valid", 32'(o_result_valid), 1);
        check_output("done_class", 32'(o_class), 32'(cls));
        check_output("done_busy_low", 32'(o_busy), 0);
        i_cnn_done = 1'b0;
        @(negedge clk);
        check_output("idle_result_valid_low", 32'(o_result_valid), 0);
        check_output("result_pulse_single", 32'(rv_count), 32'(rv0 + 1));
        check_output("idle_err_none", 32'(o_err), 0);
    endtask

    initial begin
        int fs0;
        int b0;
        int rv0;
        reset_n      = 1'b0;
        i_start      = 1'b0;
        i_sel        = 4'd0;
        i_feed_valid = 1'b0;
        i_cnn_done   = 1'b0;
        i_cnn_class  = 4'd0;

        repeat (2) @(negedge clk);
        check_output("rst_feed_start", 32'(o_feed_start), 0);
        check_output("rst_feed_sel", 32'(o_feed_sel), 0);
        check_output("rst_class", 32'(o_class), 0);
        check_output("rst_result_valid", 32'(o_result_valid), 0);
        check_output("rst_busy", 32'(o_busy), 0);
        check_output("rst_err", 32'(o_err), 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] normal run sel=3 class=5");
        start_run(4'd3);
        feed(784);
        i_feed_valid = 1'b0;
        check_output("wait_busy", 32'(o_busy), 1);
        check_output("wait_feed_sel_stable", 32'(o_feed_sel), 3);
        finish_run(4'd5, 100);

        $display("[TB] bad selection sel=12");
        fs0 = fs_count;
        b0  = busy_count;
        i_sel   = 4'd12;
        i_start = 1'b1;
        @(negedge clk);
        check_output("badsel_err", 32'(o_err), 1);
        check_output("badsel_busy", 32'(o_busy), 0);
        check_output("badsel_feed_start", 32'(o_feed_start), 0);
        check_output("badsel_feed_sel", 32'(o_feed_sel), 12);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("badsel_no_pulse", 32'(fs_count), 32'(fs0));
        check_output("badsel_never_busy", 32'(busy_count), 32'(b0));
        check_output("badsel_err_held", 32'(o_err), 1);
        check_output("badsel_class_kept", 32'(o_class), 5);

        $display("[TB] short stream after 500 pixels");
        start_run(4'd1);
        feed(500);
        i_feed_valid = 1'b0;
        check_output("short_before_err", 32'(o_err), 0);
        check_output("short_before_busy", 32'(o_busy), 1);
        @(negedge clk);
        check_output("short_err", 32'(o_err), 2);
        check_output("short_busy_low", 32'(o_busy), 0);
        check_output("short_class_kept", 32'(o_class), 5);

        $display("[TB] CNN timeout, extra valids ignored");
        start_run(4'd2);
        feed(784);
        repeat (3) @(negedge clk);
        i_feed_valid = 1'b0;
        repeat (4092) @(negedge clk);
        check_output("timeout_edge_err", 32'(o_err), 0);
        check_output("timeout_edge_busy", 32'(o_busy), 1);
        @(negedge clk);
        check_output("timeout_err", 32'(o_err), 3);
        check_output("timeout_busy_low", 32'(o_busy), 0);
        check_output("timeout_class_kept", 32'(o_class), 5);
        start_run(4'd0);
        feed(784);
        i_feed_valid = 1'b0;
        finish_run(4'd9, 5);

        $display("[TB] stray start and done during stream");
        fs0 = fs_count;
        rv0 = rv_count;
        start_run(4'd7);
        for (int i = 0; i < 784; i++) begin
            i_feed_valid = 1'b1;
            i_start      = (i == 200);
            i_cnn_done   = (i == 200);
            i_cnn_class  = 4'd2;
            @(negedge clk);
        end
        i_feed_valid = 1'b0;
        check_output("stray_busy", 32'(o_busy), 1);
        check_output("stray_class_kept", 32'(o_class), 9);
        check_output("stray_feed_sel", 32'(o_feed_sel), 7);
        check_output("stray_no_result", 32'(rv_count), 32'(rv0));
        finish_run(4'd4, 10);
        check_output("stray_single_start", 32'(fs_count), 32'(fs0 + 1));

        $display("[TB] reset mid-stream");
        start_run(4'd4);
        feed(300);
        #2 reset_n = 1'b0;
        #1;
        check_output("arst_feed_start", 32'(o_feed_start), 0);
        check_output("arst_feed_sel", 32'(o_feed_sel), 0);
        check_output("arst_class", 32'(o_class), 0);
        check_output("arst_result_valid", 32'(o_result_valid), 0);
        check_output("arst_busy", 32'(o_busy), 0);
        check_output("arst_err", 32'(o_err), 0);
        i_feed_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_run(4'd5);
        feed(784);
        i_feed_valid = 1'b0;
        finish_run(4'd3, 2);
        check_output("post_rst_feed_sel", 32'(o_feed_sel), 5);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
